// File: rtl/axi_read_resp.sv
// AXI read-response engine: walks one AR descriptor at a time through the
// cache data array and returns the beats on the R channel.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a descriptor; desc_ready high
// REQ   | one-cycle mem_req for the current beat (suppressed on error)
// WAIT  | capture mem_rdata (or zero) into the rdata register
// RESP  | rvalid high; hold the beat until rready, then advance or finish
module axi_read_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           desc_valid,
  output logic                           desc_ready,
  input  logic [ADDR_WIDTH+ID_WIDTH+12:0] desc_data,
  output logic                           mem_req,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [ID_WIDTH-1:0]            rid,
  output logic [1:0]                     rresp,
  output logic                           rlast,
  output logic                           busy
);

  // Largest legal arsize: 4-byte beats on a 32-bit bus, 8-byte on 64-bit.
  localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            burst_q;
  logic [2:0]            size_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] d_addr;
  logic [ID_WIDTH-1:0]   d_id;
  logic [1:0]            d_burst;
  logic [2:0]            d_size;
  logic [7:0]            d_len;

  assign {d_addr, d_id, d_burst, d_size, d_len} = desc_data;
  assign mem_addr = addr_q;

  // Descriptor legality, judged once at accept time and carried for the burst.
  logic                  d_err;
  logic [ADDR_WIDTH-1:0] d_bytes;
  logic                  d_bad_len;
  always_comb begin
    d_bytes   = ADDR_WIDTH'(1) << d_size;
    d_bad_len = !((d_len == 8'd1) || (d_len == 8'd3) || (d_len == 8'd7) || (d_len == 8'd15));
    d_err     = 1'b0;
    if (d_burst == 2'b11)
      d_err = 1'b1;
    if (d_size > MAX_SIZE)
      d_err = 1'b1;
    if ((d_burst == 2'b10) && d_bad_len)
      d_err = 1'b1;
    if ((d_burst == 2'b10) && ((d_addr & (d_bytes - ADDR_WIDTH'(1))) != '0))
      d_err = 1'b1;
  end

  // Address of the following beat for FIXED / INCR / WRAP.
  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] low;
  logic [ADDR_WIDTH-1:0] next_addr;
  always_comb begin
    bytes = ADDR_WIDTH'(1) << size_q;
    span  = bytes * (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1));
    low   = addr_q & ~(span - ADDR_WIDTH'(1));
    case (burst_q)
      2'b01:   next_addr = (addr_q & ~(bytes - ADDR_WIDTH'(1))) + bytes;
      2'b10:   next_addr = low + ((addr_q + bytes - low) & (span - ADDR_WIDTH'(1)));
      default: next_addr = addr_q;
    endcase
  end

  // Sequencer with all handshake and R outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      burst_q    <= '0;
      size_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      desc_ready <= 1'b1;
      mem_req    <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      rid        <= '0;
      rresp      <= 2'b00;
      rlast      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (desc_valid) begin
            addr_q     <= d_addr;
            rid        <= d_id;
            burst_q    <= d_burst;
            size_q     <= d_size;
            len_q      <= d_len;
            err_q      <= d_err;
            cnt_q      <= 8'd0;
            desc_ready <= 1'b0;
            busy       <= 1'b1;
            mem_req    <= !d_err;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          mem_req <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          rdata   <= err_q ? '0 : mem_rdata;
          rresp   <= err_q ? 2'b10 : 2'b00;
          rlast   <= (cnt_q == len_q);
          rvalid  <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (rlast) begin
              desc_ready <= 1'b1;
              busy       <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              addr_q  <= next_addr;
              mem_req <= !err_q;
              state_q <= S_REQ;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
